shift_exec_stage: RTL



---
 rtl/shift_exec_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/shift_exec_stage.sv
// shift_exec_stage: registered shift/rotate execute stage with a one-entry skid buffer.
// Define SHIFT_ROTATE_EN to enable ROL/ROR; without it opcodes 011/100 are reported as illegal.
module shift_exec_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [3:0]       in_mag,
  input  logic [3:0]       in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [3:0]       out_tag,
  output logic             out_c,
  output logic             out_z,
  output logic             out_n,
  output logic             out_err
);
  // state | meaning
  // EMPTY | no result held
  // ONE   | result in output register, skid empty
  // FULL  | output and skid registers both hold results, in_ready low
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [3:0]       tag;
    logic             c;
    logic             z;
    logic             n;
    logic             err;
  } res_t;

  localparam logic [2:0] OP_SHL = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b001;
  localparam logic [2:0] OP_SAR = 3'b010;
`ifdef SHIFT_ROTATE_EN
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
`endif

  state_t           state;
  res_t             nxt, out_r, skid;
  logic             accept, drain;
  logic [WIDTH:0]   shl_ext, shr_ext;
  logic [WIDTH-1:0] sar_val;

  // Extended shifts capture the last bit shifted out as carry; m=0 yields 0 naturally.
  assign shl_ext = {1'b0, in_a} << in_mag;
  assign shr_ext = {in_a, 1'b0} >> in_mag;
  assign sar_val = $unsigned($signed(in_a) >>> in_mag);

`ifdef SHIFT_ROTATE_EN
  logic [WIDTH-1:0] rol_val, ror_val;
  assign rol_val = (in_a << in_mag) | (in_a >> (5'(WIDTH) - {1'b0, in_mag}));
  assign ror_val = (in_a >> in_mag) | (in_a << (5'(WIDTH) - {1'b0, in_mag}));
`endif

  always_comb begin
    nxt     = '0;
    nxt.q   = in_a;
    nxt.tag = in_tag;
    case (in_op)
      OP_SHL: begin nxt.q = shl_ext[WIDTH-1:0]; nxt.c = shl_ext[WIDTH]; end
      OP_SHR: begin nxt.q = shr_ext[WIDTH:1];   nxt.c = shr_ext[0];     end
      OP_SAR: begin nxt.q = sar_val;            nxt.c = shr_ext[0];     end
`ifdef SHIFT_ROTATE_EN
      OP_ROL: begin nxt.q = rol_val; nxt.c = (in_mag != 4'd0) & rol_val[0];       end
      OP_ROR: begin nxt.q = ror_val; nxt.c = (in_mag != 4'd0) & ror_val[WIDTH-1]; end
`endif
      default: nxt.err = 1'b1;
    endcase
    nxt.z = (nxt.q == '0);
    nxt.n = nxt.q[WIDTH-1];
  end

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_r     <= '0;
      skid      <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          out_r     <= nxt;
          out_valid <= 1'b1;
          state     <= ONE;
        end
        ONE: begin
          if (accept && drain) begin
            out_r <= nxt;
          end else if (accept) begin
            skid     <= nxt;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: if (drain) begin
          out_r    <= skid;
          in_ready <= 1'b1;
          state    <= ONE;
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_q   = out_r.q;
  assign out_tag = out_r.tag;
  assign out_c   = out_r.c;
  assign out_z   = out_r.z;
  assign out_n   = out_r.n;
  assign out_err = out_r.err;

endmodule
